// File: rtl/sync_tx_scheduler.sv
// Source-side scheduler for the bus-enable synchronizer crossing.
// Define SYNC_SCHED_FIXED_PRIO_EN for fixed priority instead of round-robin.
module sync_tx_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_WIDTH  = 8,
  parameter int HOLD_CYCLES = 3,
  parameter int GAP_CYCLES  = 2,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [DATA_WIDTH-1:0]         unsync_bus,
  output logic                          bus_enable,
  output logic [IDW-1:0]                src_id,
  output logic                          busy
);

  localparam int MAXC =
    (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW = $clog2(MAXC) + 1;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    GAP
  } state_t;

  state_t                  state, state_nxt;
  logic [CW-1:0]           cnt, cnt_nxt;
  logic [NUM_REQ-1:0]      gnt_nxt;
  logic [DATA_WIDTH-1:0]   bus_nxt;
  logic                    en_nxt;
  logic [IDW-1:0]          id_nxt;
  logic                    busy_nxt;
  logic [IDW-1:0]          win;
  logic [IDW-1:0]          rr_ptr;
  logic [IDW-1:0]          rr_nxt;

  // Descending scan so the lowest search offset is assigned last and wins.
  always_comb begin
    win = '0;
`ifdef SYNC_SCHED_FIXED_PRIO_EN
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[i]) win = IDW'(i);
`else
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[(int'(rr_ptr) + i) % NUM_REQ])
        win = IDW'((int'(rr_ptr) + i) % NUM_REQ);
`endif
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    gnt_nxt   = '0;
    bus_nxt   = unsync_bus;
    en_nxt    = bus_enable;
    id_nxt    = src_id;
    busy_nxt  = busy;
    rr_nxt    = rr_ptr;
    unique case (state)
      IDLE: begin
        if (|req) begin
          state_nxt    = HOLD;
          cnt_nxt      = CW'(HOLD_CYCLES - 1);
          gnt_nxt[win] = 1'b1;
          bus_nxt      = req_data[int'(win)*DATA_WIDTH +: DATA_WIDTH];
          en_nxt       = 1'b1;
          id_nxt       = win;
          busy_nxt     = 1'b1;
          rr_nxt       = IDW'((int'(win) + 1) % NUM_REQ);
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nxt = GAP;
          cnt_nxt   = CW'(GAP_CYCLES - 1);
          en_nxt    = 1'b0;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
        end else begin
          cnt_nxt = cnt - CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        busy_nxt  = 1'b0;
        en_nxt    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      cnt        <= '0;
      gnt        <= '0;
      unsync_bus <= '0;
      bus_enable <= 1'b0;
      src_id     <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      gnt        <= gnt_nxt;
      unsync_bus <= bus_nxt;
      bus_enable <= en_nxt;
      src_id     <= id_nxt;
      busy       <= busy_nxt;
    end
  end

`ifdef SYNC_SCHED_FIXED_PRIO_EN
  assign rr_ptr = '0;
  logic unused_rr;
  assign unused_rr = ^rr_nxt;
`else
  always_ff @(posedge CLK) begin
    if (RST) rr_ptr <= '0;
    else     rr_ptr <= rr_nxt;
  end
`endif

endmodule

// File: tb/tb_sync_tx_scheduler.sv
// Directed-vector bench for sync_tx_scheduler.
// Covers reset, single transfer timing, round-robin order/wrap and late requests.
module tb_sync_tx_scheduler;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [7:0]  unsync_bus;
  logic        bus_enable;
  logic [1:0]  src_id;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;

  sync_tx_scheduler dut (
    .CLK        (CLK),
    .RST        (RST),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .unsync_bus (unsync_bus),
    .bus_enable (bus_enable),
    .src_id     (src_id),
    .busy       (busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Wait (bounded) for a grant, check it, drop that request, run to IDLE.
  task automatic grab(input int exp_idx, input string tag);
    logic [3:0] g;
    g = '0;
    for (int t = 0; t < 10 && g == '0; t++) begin
      tick();
      g = gnt;
    end
    chk(tag, {28'd0, g}, 32'd1 << exp_idx);
    req = req & ~g;
    repeat (5) tick();
  endtask

  initial begin
    int exp_i;
    RST = 1'b1;
    req = '0;
    req_data = '0;
    tick();
    tick();
    RST = 1'b0;
    chk("rst_gnt", {28'd0, gnt}, 0);
    chk("rst_en", {31'd0, bus_enable}, 0);
    chk("rst_busy", {31'd0, busy}, 0);

    // 1: reset in the middle of HOLD
    req = 4'b0001;
    req_data[7:0] = 8'h3C;
    tick();
    chk("t1_gnt", {28'd0, gnt}, 32'h1);
    req = '0;
    tick();
    RST = 1'b1;
    tick();
    chk("t1_rst_en", {31'd0, bus_enable}, 0);
    chk("t1_rst_bus", {24'd0, unsync_bus}, 0);
    chk("t1_rst_busy", {31'd0, busy}, 0);
    chk("t1_rst_gnt", {28'd0, gnt}, 0);
    tick();
    RST = 1'b0;
    tick();
    chk("t1_idle_busy", {31'd0, busy}, 0);
    chk("t1_idle_en", {31'd0, bus_enable}, 0);

    // 2: single transfer timing
    req = 4'b0010;
    req_data[15:8] = 8'hA5;
    tick();
    chk("t2_gnt", {28'd0, gnt}, 32'h2);
    chk("t2_en1", {31'd0, bus_enable}, 1);
    chk("t2_bus", {24'd0, unsync_bus}, 32'hA5);
    chk("t2_id", {30'd0, src_id}, 1);
    chk("t2_busy", {31'd0, busy}, 1);
    req = '0;
    req_data = '0;
    tick();
    chk("t2_gnt_off", {28'd0, gnt}, 0);
    chk("t2_en2", {31'd0, bus_enable}, 1);
    tick();
    chk("t2_en3", {31'd0, bus_enable}, 1);
    tick();
    chk("t2_gap1_en", {31'd0, bus_enable}, 0);
    chk("t2_gap1_bus", {24'd0, unsync_bus}, 32'hA5);
    chk("t2_gap1_id", {30'd0, src_id}, 1);
    tick();
    chk("t2_gap2_en", {31'd0, bus_enable}, 0);
    chk("t2_gap2_busy", {31'd0, busy}, 1);
    tick();
    chk("t2_idle_busy", {31'd0, busy}, 0);

    // 3: all requesters held from a fresh reset, period of 6
    RST = 1'b1;
    tick();
    RST = 1'b0;
    req_data = 32'h13121110;
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
`ifdef SYNC_SCHED_FIXED_PRIO_EN
      exp_i = 0;
`else
      exp_i = n % 4;
`endif
      tick();
      chk("t3_gnt", {28'd0, gnt}, 32'd1 << exp_i);
      chk("t3_id", {30'd0, src_id}, exp_i);
      chk("t3_bus", {24'd0, unsync_bus}, 32'h10 + exp_i);
      chk("t3_en", {31'd0, bus_enable}, 1);
      if (n < 4) begin
        tick();
        chk("t3_h2", {31'd0, bus_enable}, 1);
        tick();
        chk("t3_h3", {31'd0, bus_enable}, 1);
        tick();
        chk("t3_g1", {31'd0, bus_enable}, 0);
        tick();
        chk("t3_g2", {31'd0, bus_enable}, 0);
        tick();
        chk("t3_idle", {31'd0, busy}, 0);
      end
    end
    req = '0;
    repeat (5) tick();

    // 4: wrap from rr_ptr=3
    req_data = '0;
    req = 4'b0100;
    grab(2, "t4_pre");
    req = 4'b1001;
`ifdef SYNC_SCHED_FIXED_PRIO_EN
    grab(0, "t4_first");
    grab(3, "t4_second");
`else
    grab(3, "t4_first");
    grab(0, "t4_second");
`endif

    // 5: request raised mid-HOLD waits for the next IDLE
    req = 4'b0001;
    req_data[7:0] = 8'h55;
    tick();
    chk("t5_gnt0", {28'd0, gnt}, 32'h1);
    req = '0;
    tick();
    req[2] = 1'b1;
    req_data[23:16] = 8'h77;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t5_bus_hold", {24'd0, unsync_bus}, 32'h55);
      chk("t5_no_gnt", {28'd0, gnt}, 0);
    end
    tick();
    chk("t5_idle_busy", {31'd0, busy}, 0);
    chk("t5_idle_bus", {24'd0, unsync_bus}, 32'h55);
    tick();
    chk("t5_gnt2", {28'd0, gnt}, 32'h4);
    chk("t5_bus2", {24'd0, unsync_bus}, 32'h77);
    req = '0;
    repeat (5) tick();

    // 6: req 1 and 3 held together
    req = 4'b1010;
    for (int n = 0; n < 3; n++) begin
      logic [3:0] g;
      g = '0;
      for (int t = 0; t < 10 && g == '0; t++) begin
        tick();
        g = gnt;
      end
`ifdef SYNC_SCHED_FIXED_PRIO_EN
      chk("t6_gnt", {28'd0, g}, 32'h2);
`else
      chk("t6_gnt", {28'd0, g}, (n % 2 == 0) ? 32'h8 : 32'h2);
`endif
    end
    req = '0;
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
